// File: rtl/vga_timing_if.sv
// vga_timing_if: pixel bus to img_generator plus VGA pin outputs; master = timing generator, slave = consumer
interface vga_timing_if;
  logic [11:0] x;
  logic [11:0] y;
  logic        active;
  logic        frame_start;
  logic [2:0]  color_in;
  logic        VGA_R;
  logic        VGA_G;
  logic        VGA_B;
  logic        VGA_HS;
  logic        VGA_VS;
  modport master (output x, y, active, frame_start, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, input color_in);
  modport slave  (input x, y, active, frame_start, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, output color_in);
endinterface

// File: rtl/vga_timing.sv
// vga_timing: 640x480@60 VGA timing (CLOCK_25, async active-low rst_n, bus: x/y/active/frame_start out, color_in in, VGA_* pins out); VGA_ONE_BASED_EN makes x/y one-based
module vga_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic          CLOCK_25,
  input  logic          rst_n,
  vga_timing_if.master  bus
);
  localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_ACT  = 10'(H_VISIBLE);
  localparam logic [9:0] V_ACT  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
`ifdef VGA_ONE_BASED_EN
  localparam logic [11:0] OFS = 12'd1;
`else
  localparam logic [11:0] OFS = 12'd0;
`endif
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_end;
  logic       v_end;
  assign h_end      = h_cnt == H_LAST;
  assign v_end      = v_cnt == V_LAST;
  assign bus.x      = {2'b00, h_cnt} + OFS;
  assign bus.y      = {2'b00, v_cnt} + OFS;
  assign bus.active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  // colour and syncs share one register stage so they reach the pins aligned
  always_ff @(posedge CLOCK_25 or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt                           <= '0;
      v_cnt                           <= '0;
      {bus.VGA_R, bus.VGA_G, bus.VGA_B} <= 3'b000;
      bus.VGA_HS                      <= 1'b1;
      bus.VGA_VS                      <= 1'b1;
      bus.frame_start                 <= 1'b0;
    end else begin
      h_cnt                           <= h_end ? '0 : h_cnt + 10'd1;
      v_cnt                           <= h_end ? (v_end ? '0 : v_cnt + 10'd1) : v_cnt;
      {bus.VGA_R, bus.VGA_G, bus.VGA_B} <= bus.active ? bus.color_in : 3'b000;
      bus.VGA_HS                      <= !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
      bus.VGA_VS                      <= !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
      bus.frame_start                 <= h_end && v_end;
    end
  end
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: scoreboard bench; full horizontal timing, vertical shortened to 8 lines so two frames fit the cycle budget
module tb_vga_timing;
  typedef struct packed {
    logic [2:0]  rgb;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        act;
    logic [11:0] x;
    logic [11:0] y;
  } obs_t;
`ifdef VGA_ONE_BASED_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif
  localparam int FRAME = 800 * 8;
  logic CLOCK_25;
  logic rst_n;
  logic mode;
  int   tests;
  int   fails;
  int   fs_cnt;
  int   hs_low_cnt;
  obs_t q[$];
  vga_timing_if bus();
  vga_timing #(
    .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut (
    .CLOCK_25(CLOCK_25),
    .rst_n(rst_n),
    .bus(bus)
  );
  // mode 0: constant white; mode 1: red only at the last active column
  assign bus.color_in = mode ? ((bus.x == 12'(639 + OFS)) ? 3'b100 : 3'b000) : 3'b111;
  initial begin
    CLOCK_25 = 1'b0;
    forever #5 CLOCK_25 = ~CLOCK_25;
  end
  function automatic obs_t obs();
    return {bus.VGA_R, bus.VGA_G, bus.VGA_B, bus.VGA_HS, bus.VGA_VS, bus.frame_start, bus.active, bus.x, bus.y};
  endfunction
  // expected outputs in cycle n after release; pm = colour mode used in cycle n-1
  function automatic obs_t model(int n, bit pm);
    obs_t o;
    int h = n % 800;
    int v = (n / 800) % 8;
    int ph = (n - 1) % 800;
    int pv = ((n - 1) / 800) % 8;
    o.x   = 12'(h + OFS);
    o.y   = 12'(v + OFS);
    o.act = (h < 640) && (v < 4);
    if (n == 0) begin
      o.rgb = 3'b000;
      o.hs  = 1'b1;
      o.vs  = 1'b1;
      o.fs  = 1'b0;
    end else begin
      o.rgb = (ph < 640 && pv < 4) ? (pm ? ((ph == 639) ? 3'b100 : 3'b000) : 3'b111) : 3'b000;
      o.hs  = !(ph >= 656 && ph <= 751);
      o.vs  = !(pv == 5 || pv == 6);
      o.fs  = (ph == 799) && (pv == 7);
    end
    return o;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge CLOCK_25) begin
    if (q.size() > 0) begin
      obs_t e;
      obs_t a;
      e = q.pop_front();
      a = obs();
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL cycle @%0t: got rgb=%b hs=%b vs=%b fs=%b act=%b x=%0d y=%0d expected rgb=%b hs=%b vs=%b fs=%b act=%b x=%0d y=%0d",
                 $time, a.rgb, a.hs, a.vs, a.fs, a.act, a.x, a.y, e.rgb, e.hs, e.vs, e.fs, e.act, e.x, e.y);
      end
      fs_cnt     += int'(a.fs);
      hs_low_cnt += int'(!a.hs);
    end
  end
  function automatic bit mode_a(int n);
    return (n >= FRAME) && (n < 2 * FRAME);
  endfunction
  initial begin
    tests = 0;
    fails = 0;
    fs_cnt = 0;
    hs_low_cnt = 0;
    mode = 1'b0;
    rst_n = 1'b0;
    repeat (5) @(posedge CLOCK_25);
    @(negedge CLOCK_25);
    chk("rst_rgb", 32'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), 32'd0);
    chk("rst_hs", 32'(bus.VGA_HS), 32'd1);
    chk("rst_vs", 32'(bus.VGA_VS), 32'd1);
    chk("rst_fs", 32'(bus.frame_start), 32'd0);
    chk("rst_x", 32'(bus.x), 32'(OFS));
    chk("rst_y", 32'(bus.y), 32'(OFS));
    chk("rst_active", 32'(bus.active), 32'd1);
    @(posedge CLOCK_25);
    #1 rst_n = 1'b1;
    // two full frames plus 2 lines and 300 pixels, ending at h=300 v=2
    for (int n = 0; n < 2 * FRAME + 1900; n++) begin
      mode = mode_a(n);
      q.push_back(model(n, n > 0 ? mode_a(n - 1) : 1'b0));
      @(posedge CLOCK_25);
    end
    #1;
    chk("pre_rst_rgb", 32'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), 32'd7);
    chk("pre_rst_x", 32'(bus.x), 32'(300 + OFS));
    #1 rst_n = 1'b0;
    #1;
    chk("async_rgb", 32'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), 32'd0);
    chk("async_x", 32'(bus.x), 32'(OFS));
    chk("async_y", 32'(bus.y), 32'(OFS));
    chk("async_hs", 32'(bus.VGA_HS), 32'd1);
    chk("async_vs", 32'(bus.VGA_VS), 32'd1);
    chk("async_fs", 32'(bus.frame_start), 32'd0);
    chk("async_active", 32'(bus.active), 32'd1);
    repeat (5) @(posedge CLOCK_25);
    #1 rst_n = 1'b1;
    mode = 1'b0;
    for (int n = 0; n <= FRAME; n++) begin
      q.push_back(model(n, 1'b0));
      @(posedge CLOCK_25);
    end
    repeat (2) @(negedge CLOCK_25);
    chk("q_drained", 32'(q.size()), 32'd0);
    // pulses at cycles 6400 and 12800 before the reset, 6400 after it
    chk("fs_total", 32'(fs_cnt), 32'd3);
    // 18 full lines before the reset and 8 after, 96 low cycles each
    chk("hs_low_total", 32'(hs_low_cnt), 32'd2496);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
